// File: rtl/uart_port.sv
// uart_port: memory-mapped 8N1 serial port. Bus writes are queued in a small
// TX FIFO and serialised on txd; frames on rxd are deserialised into a
// one-byte holding register. Status flags toward the bus are active-low.
module uart_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       _uart_in,
    input  logic       _uart_out,
    output logic [7:0] data_out,
    output logic       _uart_out_ready,
    output logic       _uart_in_ready,
    output logic       _rx_overrun,
    output logic       txd,
    input  logic       rxd
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BCW   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(TX_DEPTH);
    localparam logic [BCW-1:0]   BIT_END   = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]   HALF_END  = BCW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]       r_mem [TX_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop, w_full, w_empty;

    assign w_full          = (r_count == FIFO_FULL);
    assign w_empty         = (r_count == '0);
    assign w_push          = !_uart_in && !w_full;   // writes to a full FIFO are dropped
    assign _uart_out_ready = w_full;

    // Store accepted bus bytes.
    // NOTE: the data array has no reset; the pointers and count alone say which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

    // Advance pointers and occupancy; push and pop together leave the count unchanged.
    // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_t        r_tx_state, w_tx_state_nx;
    logic [BCW-1:0]   r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]       r_tx_bit, w_tx_bit_nx;
    logic [7:0]       r_tx_shift, w_tx_shift_nx;
    logic             r_txd, w_txd_nx;

    assign txd = r_txd;

    // TX next state: pop in IDLE, then start bit, 8 data bits LSB first, stop bit.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + 1'b1;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_pop         = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nx = '0;
                w_txd_nx    = 1'b1;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_tx_shift_nx = r_mem[r_rd_ptr];
                    w_txd_nx      = 1'b0;
                    w_tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_txd_nx      = r_tx_shift[0];
                    w_tx_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_txd_nx      = 1'b1;
                        w_tx_state_nx = TX_STOP;
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + 1'b1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == BIT_END) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_IDLE;
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    // TX state register; txd is registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
        end
    end

    // ---------------------------------------------------------------- RX path
    logic           r_rx_meta, r_rxs;
    rx_state_t      r_rx_state, w_rx_state_nx;
    logic [BCW-1:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]     r_rx_bit, w_rx_bit_nx;
    logic [7:0]     r_rx_shift, w_rx_shift_nx;
    logic           r_rx_done, w_rx_done_nx;
    logic           r_rx_full, r_overrun;
    logic [7:0]     r_data_out;
    logic           w_read;

    assign w_read         = !_uart_out;
    assign data_out       = r_data_out;
    assign _uart_in_ready = !r_rx_full;
    assign _rx_overrun    = !r_overrun;

    // Two-flop synchroniser for the asynchronous rxd pin; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rxs     <= r_rx_meta;
        end
    end

    // RX next state: qualify the start bit at mid-bit, then sample each bit at its centre.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + 1'b1;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_done_nx  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nx = '0;
                if (!r_rxs) w_rx_state_nx = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == HALF_END) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_state_nx = r_rxs ? RX_IDLE : RX_DATA;   // high again = glitch
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == BIT_END) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rxs, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
                    else                  w_rx_bit_nx   = r_rx_bit + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == BIT_END) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_done_nx  = r_rxs;   // low stop bit: framing error, byte silently dropped
                    w_rx_state_nx = RX_IDLE;
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    // RX state register plus one-cycle good-frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_done  <= w_rx_done_nx;
        end
    end

    // Holding register: load on a good frame if empty or being read, else flag a sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_full  <= 1'b0;
            r_data_out <= 8'h00;
            r_overrun  <= 1'b0;
        end else if (r_rx_done) begin
            if (!r_rx_full || w_read) begin
                r_data_out <= r_rx_shift;
                r_rx_full  <= 1'b1;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (w_read) begin
            r_rx_full <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: self-checking bench for uart_port. TX output is compared
// cycle by cycle against a waveform built from a transaction-level FIFO model;
// RX is driven with jittered frames and checked against a holding-register model.
module tb_uart_port;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int NCYC  = 900;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic       _uart_in  = 1'b1;
    logic       _uart_out = 1'b1;
    logic       tb_rxd    = 1'b1;
    logic       loop_en   = 1'b0;
    logic [7:0] data_out;
    logic       _uart_out_ready, _uart_in_ready, _rx_overrun, txd;
    logic       w_rxd;

    assign w_rxd = loop_en ? txd : tb_rxd;

    int n_checks = 0;
    int n_errors = 0;

    // TX stimulus table and captured / expected waveforms
    logic       wr_en_a  [16];
    logic [7:0] wr_dat_a [16];
    logic       exp_txd [NCYC];
    logic       exp_rdy [NCYC];
    logic       got_txd [NCYC];
    logic       got_rdy [NCYC];

    // RX reference model: holding register contents and sticky overrun
    logic       m_full = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovr  = 1'b0;

    uart_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        ._uart_in        (_uart_in),
        ._uart_out       (_uart_out),
        .data_out        (data_out),
        ._uart_out_ready (_uart_out_ready),
        ._uart_in_ready  (_uart_in_ready),
        ._rx_overrun     (_rx_overrun),
        .txd             (txd),
        .rxd             (w_rxd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        _uart_in  = 1'b1;
        _uart_out = 1'b1;
        tb_rxd    = 1'b1;
        loop_en   = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_full = 1'b0;
        m_ovr  = 1'b0;
        m_data = 8'h00;
    endtask

    task automatic test_reset();
        int lows;
        do_reset();
        n_checks++; if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd got %b want 1", txd); end
        n_checks++; if (_uart_out_ready !== 1'b0) begin n_errors++; $display("FAIL reset_out_ready got %b want 0", _uart_out_ready); end
        n_checks++; if (_uart_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", _uart_in_ready); end
        n_checks++; if (_rx_overrun !== 1'b1) begin n_errors++; $display("FAIL reset_overrun got %b want 1", _rx_overrun); end
        n_checks++; if (data_out !== 8'h00) begin n_errors++; $display("FAIL reset_data_out got %h want 00", data_out); end
        // Start a frame of 8'h3C and reset it while data bit 0 (a zero) is on the line.
        data_in  = 8'h3C;
        _uart_in = 1'b0;
        @(negedge clk);
        _uart_in = 1'b1;
        repeat (24) @(negedge clk);
        n_checks++; if (txd !== 1'b0) begin n_errors++; $display("FAIL reset_pre_txd got %b want 0", txd); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_mid_txd got %b want 1", txd); end
        n_checks++; if (_uart_out_ready !== 1'b0) begin n_errors++; $display("FAIL reset_mid_out_ready got %b want 0", _uart_out_ready); end
        n_checks++; if (_uart_in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_mid_in_ready got %b want 1", _uart_in_ready); end
        n_checks++; if (_rx_overrun !== 1'b1) begin n_errors++; $display("FAIL reset_mid_overrun got %b want 1", _rx_overrun); end
        @(negedge clk);
        reset = 1'b0;
        lows  = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_checks++; if (lows != 0) begin n_errors++; $display("FAIL reset_abort txd low for %0d cycles, want 0", lows); end
    endtask

    // Drive the write table, capture txd/_uart_out_ready, compare with the model waveform.
    // Model: a write is taken when occupancy < DEPTH; the transmitter pops whenever it is
    // free and data is queued, each frame occupies FRAME cycles plus one idle cycle.
    task automatic run_tx(input string name, input int n_wr);
        int         cnt, next_free, n_bad, first_bad, bi, c;
        logic [7:0] q[$];
        logic [7:0] b;
        bit         push, pop;
        cnt       = 0;
        next_free = 0;
        for (int i = 0; i < NCYC; i++) exp_txd[i] = 1'b1;
        for (int e = 0; e < NCYC; e++) begin
            pop  = (e >= next_free) && (cnt != 0);
            push = 1'b0;
            if (e < n_wr) push = wr_en_a[e] && (cnt != DEPTH);
            if (pop) begin
                b = q.pop_front();
                for (int k = 0; k < FRAME && e + k < NCYC; k++) begin
                    bi = k / CPB;
                    exp_txd[e + k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi - 1];
                end
                next_free = e + FRAME + 1;
            end
            if (push) q.push_back(wr_dat_a[e]);
            cnt = cnt + int'(push) - int'(pop);
            exp_rdy[e] = (cnt == DEPTH);
        end

        for (int i = 0; i < NCYC; i++) begin
            _uart_in = 1'b1;
            if (i < n_wr) begin
                data_in  = wr_dat_a[i];
                _uart_in = !wr_en_a[i];
            end
            @(negedge clk);
            got_txd[i] = txd;
            got_rdy[i] = _uart_out_ready;
        end
        _uart_in = 1'b1;

        for (int w = 0; w < NCYC / CPB; w++) begin
            n_bad     = 0;
            first_bad = 0;
            for (int k = 0; k < CPB; k++) begin
                c = w * CPB + k;
                if (got_txd[c] !== exp_txd[c]) begin
                    if (n_bad == 0) first_bad = c;
                    n_bad++;
                end
            end
            n_checks++;
            if (n_bad != 0) begin
                n_errors++;
                $display("FAIL %s_txd cycle %0d got %b want %b", name, first_bad, got_txd[first_bad], exp_txd[first_bad]);
            end
        end
        n_bad     = 0;
        first_bad = 0;
        for (int i = 0; i < NCYC; i++) begin
            if (got_rdy[i] !== exp_rdy[i]) begin
                if (n_bad == 0) first_bad = i;
                n_bad++;
            end
        end
        n_checks++;
        if (n_bad != 0) begin
            n_errors++;
            $display("FAIL %s_out_ready cycle %0d got %b want %b", name, first_bad, got_rdy[first_bad], exp_rdy[first_bad]);
        end
    endtask

    task automatic test_tx_single();
        for (int i = 0; i < 16; i++) begin wr_en_a[i] = 1'b0; wr_dat_a[i] = 8'h00; end
        wr_en_a[0]  = 1'b1;
        wr_dat_a[0] = 8'hA5;
        do_reset();
        run_tx("tx_single", 1);
    endtask

    task automatic test_tx_fifo_full();
        for (int i = 0; i < 16; i++) begin wr_en_a[i] = 1'b0; wr_dat_a[i] = 8'h00; end
        for (int i = 0; i < 6; i++) begin wr_en_a[i] = 1'b1; wr_dat_a[i] = 8'(i + 1); end
        do_reset();
        run_tx("tx_fifo_full", 6);
    endtask

    task automatic test_tx_random();
        int n;
        repeat (2) begin
            n = int'($urandom_range(12, 4));
            for (int i = 0; i < 16; i++) begin
                wr_en_a[i]  = ($urandom_range(3, 0) != 0);
                wr_dat_a[i] = 8'($urandom);
            end
            do_reset();
            run_tx("tx_random", n);
        end
    endtask

    // Drive one frame on rxd. Each bit boundary after the start edge may be moved
    // by up to +-6 clocks when jitter is on; the stop level is selectable.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit jitter);
        int edge_t [10];
        int bi;
        edge_t[0] = 0;
        for (int k = 1; k < 10; k++)
            edge_t[k] = k * CPB + (jitter ? int'($urandom_range(12, 0)) - 6 : 0);
        for (int t = 0; t < FRAME; t++) begin
            bi = 0;
            for (int k = 1; k < 10; k++) if (t >= edge_t[k]) bi = k;
            tb_rxd = (bi == 0) ? 1'b0 : (bi == 9) ? stop_bit : b[bi - 1];
            @(negedge clk);
        end
        tb_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        if (stop_bit) begin
            if (!m_full) begin
                m_full = 1'b1;
                m_data = b;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    task automatic do_read();
        _uart_out = 1'b0;
        @(negedge clk);
        _uart_out = 1'b1;
        m_full    = 1'b0;
    endtask

    task automatic check_rx(input string name);
        n_checks++;
        if (_uart_in_ready !== ~m_full) begin
            n_errors++; $display("FAIL %s_in_ready got %b want %b", name, _uart_in_ready, ~m_full);
        end
        n_checks++;
        if (_rx_overrun !== ~m_ovr) begin
            n_errors++; $display("FAIL %s_overrun got %b want %b", name, _rx_overrun, ~m_ovr);
        end
        if (m_full) begin
            n_checks++;
            if (data_out !== m_data) begin
                n_errors++; $display("FAIL %s_data got %h want %h", name, data_out, m_data);
            end
        end
    endtask

    task automatic test_rx_byte();
        do_reset();
        send_frame(8'h3C, 1'b1, 1'b0);
        check_rx("rx_byte");
        do_read();
        check_rx("rx_read");
    endtask

    task automatic test_rx_errors();
        do_reset();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check_rx("rx_overrun");
        do_read();
        check_rx("rx_overrun_read");
        tb_rxd = 1'b0;
        repeat (3) @(negedge clk);
        tb_rxd = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        check_rx("rx_glitch");
        send_frame(8'h55, 1'b0, 1'b0);
        check_rx("rx_framing");
        send_frame(8'h7E, 1'b1, 1'b0);
        check_rx("rx_recover");
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        logic       stop_bit;
        do_reset();
        repeat (10) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(7, 0) != 0);
            send_frame(b, stop_bit, 1'b1);
            check_rx("rx_random");
            if ($urandom_range(1, 0) != 0) begin
                do_read();
                check_rx("rx_random_read");
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] expv [3] = '{8'h00, 8'hFF, 8'h5A};
        int got, waited;
        do_reset();
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in  = expv[i];
            _uart_in = 1'b0;
            @(negedge clk);
        end
        _uart_in = 1'b1;
        got    = 0;
        waited = 0;
        while (got < 3 && waited < 4 * (FRAME + 1) + 200) begin
            if (_uart_in_ready === 1'b0) begin
                n_checks++;
                if (data_out !== expv[got]) begin
                    n_errors++; $display("FAIL loopback_byte%0d got %h want %h", got, data_out, expv[got]);
                end
                got++;
                _uart_out = 1'b0;
                @(negedge clk);
                _uart_out = 1'b1;
            end else begin
                @(negedge clk);
            end
            waited++;
        end
        n_checks++;
        if (got != 3) begin n_errors++; $display("FAIL loopback_count got %0d want 3", got); end
        n_checks++;
        if (_rx_overrun !== 1'b1) begin n_errors++; $display("FAIL loopback_overrun got %b want 1", _rx_overrun); end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_fifo_full();
        test_tx_random();
        test_rx_byte();
        test_rx_errors();
        test_rx_random();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
